dmem_ready_ctrl: RTL and testbench

//  M-stage data-memory responder; generates MemReady consumed by the hazard unit's memstall term.

---
 rtl/mips_mem_pkg.sv | 29 ++
 rtl/dcache_array.sv | 64 ++++++
 rtl/dmem_ready_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dmem_ready_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and address helpers for the M-stage data-memory responder.
//   dmem_state_t : responder FSM states
//   WORD_W       : data word width
//   tag_of/index_of : split a byte address into cache tag and line index
//                     for a given number of index bits (one word per line).
package mips_mem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    RESP
  } dmem_state_t;

  // Tag is everything above the word offset and the index field.
  function automatic logic [WORD_W-1:0] tag_of(input logic [WORD_W-1:0] addr,
                                               input int unsigned index_bits);
    return addr >> (index_bits + 2);
  endfunction

  // Line index sits just above the 2-bit byte offset.
  function automatic logic [WORD_W-1:0] index_of(input logic [WORD_W-1:0] addr,
                                                 input int unsigned index_bits);
    return (addr >> 2) & ((WORD_W'(1) << index_bits) - WORD_W'(1));
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped word cache storage: one 32-bit word per line.
//   clk, reset         : clock, async active-high reset (clears valid bits only)
//   rd_index, rd_tag   : combinational lookup -> hit, rdata
//   we, wr_index       : synchronous write port
//   wr_tag, wr_data    : tag/data to store
//   set_valid          : 1 = fill (valid<=1, tag and data written),
//                        0 = data-only update of an already valid line
module dcache_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_W      = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  hit,
  output logic [WORD_W-1:0]     rdata,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  set_valid
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [WORD_W-1:0] data_q [LINES];
  logic [WORD_W-1:0] data_d [LINES];

  always_comb begin
    hit   = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    rdata = data_q[rd_index];
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      data_d[wr_index] = wr_data;
      if (set_valid) begin
        valid_d[wr_index] = 1'b1;
        tag_d[wr_index]   = wr_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag/data contents are meaningless while the line is invalid, so no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dmem_ready_ctrl.sv
// M-stage data-memory responder producing MemReady for the hazard unit.
// Fronts a slow backing memory with a direct-mapped, write-through,
// no-write-allocate word cache. Read hits complete in the request cycle;
// misses and all stores wait for mem_ack, then spend one RESP cycle.
//   clk, reset              : clock, async active-high reset
//   MemtoRegM, MemWriteM    : load / store request (store wins if both)
//   ALUOutM, WriteDataM     : byte address (bits [1:0] ignored), store data
//   MemReady, ReadDataM     : completion strobe and load data
//   mem_req/we/addr/wdata   : registered backing-memory request
//   mem_ack, mem_rdata      : backing-memory completion pulse and read data
module dmem_ready_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [WORD_W-1:0] WriteDataM,
  output logic              MemReady,
  output logic [WORD_W-1:0] ReadDataM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - 2;

  dmem_state_t       state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_W-1:0] resp_data_q, resp_data_d;

  logic [WORD_W-1:0]     addr_w;
  logic [WORD_W-1:0]     tag_full, idx_full;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic                  unused_bits;

  logic              c_hit, c_we, c_set_valid;
  logic [WORD_W-1:0] c_rdata, c_wdata;
  logic              load_req, ack_valid;

  always_comb begin
    addr_w      = WORD_W'(ALUOutM);
    tag_full    = tag_of(addr_w, INDEX_BITS);
    idx_full    = index_of(addr_w, INDEX_BITS);
    req_tag     = tag_full[TAG_W-1:0];
    req_idx     = idx_full[INDEX_BITS-1:0];
    unused_bits = ^{tag_full[WORD_W-1:TAG_W], idx_full[WORD_W-1:INDEX_BITS]};
  end

  assign load_req  = MemtoRegM && !MemWriteM;
  assign ack_valid = mem_ack && mem_req_q;

  dcache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TAG_W)
  ) u_cache (
    .clk      (clk),
    .reset    (reset),
    .rd_index (req_idx),
    .rd_tag   (req_tag),
    .hit      (c_hit),
    .rdata    (c_rdata),
    .we       (c_we),
    .wr_index (req_idx),
    .wr_tag   (req_tag),
    .wr_data  (c_wdata),
    .set_valid(c_set_valid)
  );

  // Request inputs are frozen by StallM while MemReady=0, so the current
  // address also indexes the line that a fill or write-through updates.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_data_d = resp_data_q;
    c_we        = 1'b0;
    c_set_valid = 1'b0;
    c_wdata     = WriteDataM;
    MemReady    = 1'b0;
    ReadDataM   = '0;
    case (state_q)
      IDLE: begin
        if (MemWriteM) begin
          state_d     = WR_THRU;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {ALUOutM[ADDR_W-1:2], 2'b00};
          mem_wdata_d = WriteDataM;
        end else if (MemtoRegM) begin
          if (c_hit) begin
            MemReady  = 1'b1;
            ReadDataM = c_rdata;
          end else begin
            state_d    = RD_MISS;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {ALUOutM[ADDR_W-1:2], 2'b00};
          end
        end
      end
      RD_MISS: begin
        if (ack_valid) begin
          mem_req_d   = 1'b0;
          c_we        = 1'b1;
          c_set_valid = 1'b1;
          c_wdata     = mem_rdata;
          resp_data_d = mem_rdata;
          state_d     = RESP;
        end
      end
      WR_THRU: begin
        if (ack_valid) begin
          mem_req_d = 1'b0;
          c_we      = c_hit;
          state_d   = RESP;
        end
      end
      RESP: begin
        // No cache re-check here: the completed miss must not re-issue.
        MemReady = 1'b1;
        if (load_req) ReadDataM = resp_data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_ready_ctrl.sv
// Bench for dmem_ready_ctrl: directed vector table, reset-abort sequence and
// a randomized run against a word-level memory/cache reference model.
module tb_dmem_ready_ctrl;

  localparam int unsigned IB    = 4;
  localparam int unsigned LINES = 1 << IB;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic        MemReady;
  logic [31:0] ReadDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_ready_ctrl #(
    .INDEX_BITS(IB),
    .ADDR_W    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemtoRegM (MemtoRegM),
    .MemWriteM (MemWriteM),
    .ALUOutM   (ALUOutM),
    .WriteDataM(WriteDataM),
    .MemReady  (MemReady),
    .ReadDataM (ReadDataM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int unsigned w);
    return 32'h5000_0000 ^ (w * 32'h0001_0003);
  endfunction

  // ---------------- backing memory responder ----------------
  logic [31:0] bmem [int unsigned];
  bit          auto_ack = 1'b1;
  int unsigned lat = 1;
  logic        r_ack = 1'b0, man_ack = 1'b0;
  logic [31:0] r_rdata = '0, man_rdata = '0;
  int unsigned cnt = 0, txn_count = 0;
  logic        last_we = 1'b0;
  logic [31:0] last_addr = '0, last_wdata = '0;

  assign mem_ack   = auto_ack ? r_ack   : man_ack;
  assign mem_rdata = auto_ack ? r_rdata : man_rdata;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      r_ack = 1'b0;
      if (!mem_req) cnt = 0;
      else begin
        cnt++;
        if (cnt == 1) txn_count++;
        if (auto_ack && cnt == lat) begin
          int unsigned wa;
          wa         = 32'(mem_addr[31:2]);
          r_ack      = 1'b1;
          last_we    = mem_we;
          last_addr  = mem_addr;
          last_wdata = mem_wdata;
          if (mem_we) bmem[wa] = mem_wdata;
          else r_rdata = bmem.exists(wa) ? bmem[wa] : init_val(wa);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int unsigned];
  bit          ref_valid [LINES];
  int unsigned ref_word  [LINES];

  function automatic void model(input bit w, input bit r, input logic [31:0] a,
                                input logic [31:0] wd, input int unsigned l,
                                output int unsigned en, output logic [31:0] ed,
                                output int unsigned etx);
    int unsigned word, idx;
    word = 32'(a[31:2]);
    idx  = word % LINES;
    en = 0; ed = '0; etx = 0;
    if (w) begin
      en = l + 1; etx = 1;
      ref_mem[word] = wd;
    end else if (r) begin
      if (ref_valid[idx] && ref_word[idx] == word) en = 0;
      else begin
        en = l + 1; etx = 1;
        ref_valid[idx] = 1'b1;
        ref_word[idx]  = word;
      end
      ed = ref_mem.exists(word) ? ref_mem[word] : init_val(word);
    end
  endfunction

  // Present one request at drive time, wait for MemReady, then one idle cycle.
  task automatic do_req(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] wd, input int unsigned l,
                        output int unsigned n, output logic [31:0] d,
                        output int unsigned dtx, output logic idle_rdy,
                        output logic [31:0] idle_data);
    int unsigned t0;
    t0 = txn_count;
    lat = l;
    MemWriteM = w; MemtoRegM = r; ALUOutM = a; WriteDataM = wd;
    n = 0; d = 'x;
    forever begin
      @(negedge clk);
      if (MemReady) begin d = ReadDataM; break; end
      @(posedge clk);
      #1;
      n++;
      if (n > 40) break;
    end
    @(posedge clk);
    #1;
    MemWriteM = 1'b0; MemtoRegM = 1'b0; ALUOutM = $urandom; WriteDataM = $urandom;
    @(negedge clk);
    idle_rdy  = MemReady;
    idle_data = ReadDataM;
    @(posedge clk);
    #1;
    dtx = txn_count - t0;
  endtask

  task automatic run_and_check(input string tag, input bit w, input bit r,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int unsigned l, input int unsigned en,
                               input logic [31:0] ed, input int unsigned etx);
    int unsigned n, dtx;
    logic [31:0] d, idata;
    logic        irdy;
    do_req(w, r, a, wd, l, n, d, dtx, irdy, idata);
    chk({tag, " ready_cycle"}, n, en);
    chk({tag, " rdata"}, d, ed);
    chk({tag, " mem_txns"}, dtx, etx);
    chk({tag, " idle_ready"}, {31'b0, irdy}, 32'd0);
    chk({tag, " idle_rdata"}, idata, 32'd0);
    if (etx != 0 && dtx == etx) begin
      chk({tag, " mem_we"}, {31'b0, last_we}, {31'b0, w});
      chk({tag, " mem_addr"}, last_addr, {a[31:2], 2'b00});
      if (w) chk({tag, " mem_wdata"}, last_wdata, wd);
    end
  endtask

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] wd;
    int unsigned l;
    int unsigned en;
    logic [31:0] ed;
    int unsigned etx;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned en, etx;
    logic [31:0] ed;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         2, 3, 32'hDEAD_BEEF, 1};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         1, 0, 32'hDEAD_BEEF, 0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 1, 2, 32'h0,         1};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         1, 0, 32'h1234_5678, 0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0080, 32'hAAAA_5555, 1, 2, 32'h0,         1};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0080, 32'h0,         1, 2, 32'hAAAA_5555, 1};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0440, 32'h0,         3, 4, 32'h0440_CAFE, 1};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         1, 2, 32'h1234_5678, 1};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 2, 3, 32'h0,         1};
    vecs[9] = '{1'b0, 1'b1, 32'h0000_0103, 32'h0,         1, 2, 32'h0BAD_F00D, 1};

    bmem[32'h10]     = 32'hDEAD_BEEF; ref_mem[32'h10]  = 32'hDEAD_BEEF;
    bmem[32'h110]    = 32'h0440_CAFE; ref_mem[32'h110] = 32'h0440_CAFE;
    for (int i = 0; i < int'(LINES); i++) ref_valid[i] = 1'b0;

    reset = 1'b1; MemtoRegM = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset MemReady", {31'b0, MemReady}, 32'd0);
    chk("reset ReadDataM", ReadDataM, 32'd0);
    chk("reset mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      model(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].wd, vecs[i].l, en, ed, etx);
      run_and_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].r, vecs[i].a,
                    vecs[i].wd, vecs[i].l, vecs[i].en, vecs[i].ed, vecs[i].etx);
    end

    // Reset during a read miss, then a stray ack after reset is released.
    auto_ack = 1'b0;
    MemtoRegM = 1'b1; ALUOutM = 32'h0000_0200;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort mem_req_before", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort mem_req_in_reset", {31'b0, mem_req}, 32'd0);
    chk("abort ready_in_reset", {31'b0, MemReady}, 32'd0);
    MemtoRegM = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    man_ack = 1'b1; man_rdata = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    @(negedge clk);
    chk("abort mem_req_after_ack", {31'b0, mem_req}, 32'd0);
    chk("abort ready_after_ack", {31'b0, MemReady}, 32'd0);
    @(posedge clk);
    #1;
    auto_ack = 1'b1;
    for (int i = 0; i < int'(LINES); i++) ref_valid[i] = 1'b0;
    model(1'b0, 1'b1, 32'h0000_0040, 32'h0, 1, en, ed, etx);
    run_and_check("post_reset_miss", 1'b0, 1'b1, 32'h0000_0040, 32'h0, 1, 2,
                  32'h1234_5678, 1);

    // Randomized traffic over a few indices and aliasing tags.
    for (int i = 0; i < 80; i++) begin
      int unsigned op, word, l;
      bit          w, r;
      logic [31:0] a, wd;
      op   = $urandom_range(0, 5);
      word = $urandom_range(0, 2) * LINES + $urandom_range(0, 3);
      a    = (word << 2) | 32'($urandom_range(0, 3));
      wd   = $urandom;
      l    = $urandom_range(1, 4);
      w    = (op >= 4);
      r    = (op != 4);
      model(w, r, a, wd, l, en, ed, etx);
      run_and_check($sformatf("rand%0d", i), w, r, a, wd, l, en, ed, etx);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
